// File: rtl/div_recon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_recon_pkg
// Description : Shared width constants and FSM state type for div_recon_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package div_recon_pkg;

    localparam int W     = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/adder_32bits.sv
`default_nettype none
// ============================================================================
// Module      : adder_32bits
// Description : Ripple add/subtract; Ctr=0 adds, Ctr=1 subtracts b from a.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_32bits #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         Ctr,
    output logic [N-1:0] sum
);

    logic [N-1:0] w_b_eff;

    assign w_b_eff = b ^ {N{Ctr}};
    assign sum     = a + w_b_eff + N'(Ctr);

endmodule
`default_nettype wire

// File: rtl/div_recon_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_recon_seq
// Description : Rebuilds dividend = quo*divisor + mod with a radix-2 shift-add.
// Revision    : 1.0 - initial release
// ============================================================================
module div_recon_seq
    import div_recon_pkg::state_t;
    import div_recon_pkg::IDLE;
    import div_recon_pkg::MUL;
    import div_recon_pkg::ADD;
    import div_recon_pkg::DONE;
    import div_recon_pkg::CNT_W;
#(
    parameter int W = div_recon_pkg::W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   quo,
    input  logic [W-1:0]   divisor,
    input  logic [W-1:0]   mod,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] dividend,
    output logic           rem_ok,
    output logic           div_zero
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(W - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     divisor_q, divisor_d;
    logic [W-1:0]     mod_q, mod_d;
    logic [2*W-1:0]   dividend_q, dividend_d;
    logic             rem_ok_q, rem_ok_d;
    logic             div_zero_q, div_zero_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [W:0]       w_add_a, w_add_b, w_add_sum;

    // The upper half plus one carry bit is where each partial product lands.
    assign w_add_a = {1'b0, acc_q[2*W-1:W]};
    assign w_add_b = quo_q[0] ? {1'b0, divisor_q} : '0;

    adder_32bits #(.N(W + 1)) u_acc_add (
        .a   (w_add_a),
        .b   (w_add_b),
        .Ctr (1'b0),
        .sum (w_add_sum)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        quo_d      = quo_q;
        divisor_d  = divisor_q;
        mod_d      = mod_q;
        dividend_d = dividend_q;
        rem_ok_d   = rem_ok_q;
        div_zero_d = div_zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    quo_d     = quo;
                    divisor_d = divisor;
                    mod_d     = mod;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = MUL;
                end
            end
            MUL: begin
                acc_d = {w_add_sum, acc_q[W-1:1]};
                quo_d = quo_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                dividend_d = acc_q + {{W{1'b0}}, mod_q};
                rem_ok_d   = (mod_q < divisor_q);
                div_zero_d = (divisor_q == '0);
                state_d    = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake flags are registered copies of the next state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            mod_q       <= '0;
            dividend_q  <= '0;
            rem_ok_q    <= 1'b0;
            div_zero_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            quo_q       <= quo_d;
            divisor_q   <= divisor_d;
            mod_q       <= mod_d;
            dividend_q  <= dividend_d;
            rem_ok_q    <= rem_ok_d;
            div_zero_q  <= div_zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dividend  = dividend_q;
    assign rem_ok    = rem_ok_q;
    assign div_zero  = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_div_recon_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_recon_seq
// Description : Scoreboard bench for div_recon_seq against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_recon_seq;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   quo = '0;
    logic [W-1:0]   divisor = '0;
    logic [W-1:0]   mod = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] dividend;
    logic           rem_ok;
    logic           div_zero;

    typedef struct {
        logic [2*W-1:0] dividend;
        logic           rem_ok;
        logic           div_zero;
        int             acc_edge;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic have_cur = 1'b0;
    logic prev_v   = 1'b0;

    int cyc       = 0;
    int n_chk     = 0;
    int n_fail    = 0;
    int n_issued  = 0;
    int n_results = 0;

    div_recon_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quo       (quo),
        .divisor   (divisor),
        .mod       (mod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dividend  (dividend),
        .rem_ok    (rem_ok),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned arithmetic on the request.
    function automatic exp_t model(input logic [W-1:0] q, input logic [W-1:0] d,
                                   input logic [W-1:0] m, input int acc);
        exp_t e;
        e.dividend = 64'(q) * 64'(d) + 64'(m);
        e.rem_ok   = (m < d);
        e.div_zero = (d == 0);
        e.acc_edge = acc;
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] q, input logic [W-1:0] d,
                         input logic [W-1:0] m, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready_timeout", 64'(in_ready), 64'd1);
        quo      = q;
        divisor  = d;
        mod      = m;
        in_valid = 1'b1;
        acc      = cyc + 1;
        exp_q.push_back(model(q, d, m, acc));
        n_issued++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(output int at_cyc);
        int n;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready_timeout", 64'(in_ready), 64'd1);
        at_cyc = cyc;
    endtask

    // Monitor: pops on each out_valid rise, then checks the result stays put.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v   = 1'b0;
            have_cur = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'(out_valid), 64'd0);
                    have_cur = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    n_results++;
                    chk("dividend", dividend, cur.dividend);
                    chk("rem_ok", 64'(rem_ok), 64'(cur.rem_ok));
                    chk("div_zero", 64'(div_zero), 64'(cur.div_zero));
                    chk("latency", 64'(cyc - cur.acc_edge), 64'd33);
                    chk("in_ready_in_done", 64'(in_ready), 64'd0);
                end
            end else if (out_valid && have_cur) begin
                chk("hold_dividend", dividend, cur.dividend);
                chk("hold_rem_ok", 64'(rem_ok), 64'(cur.rem_ok));
                chk("hold_div_zero", 64'(div_zero), 64'(cur.div_zero));
            end
            prev_v = out_valid;
        end
    end

    initial begin
        int acc, t, n;
        logic [W-1:0] rq, rd, rm;

        // Reset state
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_dividend", dividend, 64'd0);
        chk("rst_rem_ok", 64'(rem_ok), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases
        out_ready = 1'b1;
        issue(32'd3, 32'd7, 32'd2, acc);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, acc);
        issue(32'd9, 32'd0, 32'd5, acc);
        issue(32'd0, 32'd5, 32'd3, acc);
        issue(32'd6, 32'd4, 32'd4, acc);

        // Stall in DONE for 10 cycles; a stray request during MUL must be dropped
        wait_ready(t);
        out_ready = 1'b0;
        issue(32'd100, 32'd200, 32'd50, acc);
        repeat (4) @(negedge clk);
        chk("busy_in_ready", 64'(in_ready), 64'd0);
        quo = 32'd55; divisor = 32'd66; mod = 32'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid_timeout", 64'(out_valid), 64'd1);
        repeat (10) @(negedge clk);
        chk("stall_valid_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_released", 64'(out_valid), 64'd0);
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of MUL
        issue(32'h0001_2345, 32'h0000_0777, 32'h0000_0011, acc);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_dividend", dividend, 64'd0);
        chk("arst_rem_ok", 64'(rem_ok), 64'd0);
        chk("arst_div_zero", 64'(div_zero), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        n_issued--;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(32'd1, 32'd1, 32'd0, acc);
        repeat (45) @(negedge clk);

        // Randomised back-to-back traffic with the consumer always ready
        for (int i = 0; i < 20; i++) begin
            rq = $urandom;
            rd = (i % 5 == 0) ? 32'd0 : $urandom;
            rm = (i % 2 == 0 && rd != 0) ? $urandom_range(0, 1000) % rd : $urandom;
            issue(rq, rd, rm, acc);
            wait_ready(t);
            chk("throughput", 64'(t - acc), 64'd34);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
        chk("result_count", 64'(n_results), 64'(n_issued));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_recon_seq.md
DIV_RECON_SEQ -- requirements
Module: div_recon_seq

Interface
REQ-001 Parameter W, default 32: operand width; the product and dividend are 2*W bits.
REQ-002 clk  input  1  single clock for all state, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  request carries valid quo/divisor/mod.
REQ-005 in_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 quo  input  W  quotient to reconstruct from.
REQ-007 divisor  input  W  divisor.
REQ-008 mod  input  W  remainder.
REQ-009 out_valid  output  1  result fields valid; held until accepted.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 dividend  output  2W  quo*divisor + mod, unsigned.
REQ-012 rem_ok  output  1  1 when mod < divisor (unsigned).
REQ-013 div_zero  output  1  1 when divisor == 0.

Function
REQ-014 The block shall be the inverse of the 64/32 divider: it rebuilds the dividend from quo, divisor and mod for self-check of the divide path.
REQ-015 The FSM shall have states IDLE, MUL, ADD and DONE, and no others.
REQ-016 IDLE: in_ready=1; on the edge where in_valid=1, the block shall latch the operands, clear the accumulator and the 6-bit counter, and enter MUL.
REQ-017 MUL: each edge, if the current quo LSB is 1, the block shall add divisor to the upper W+1 accumulator bits, then shift the accumulator and quo right by 1; this shall be radix-2 shift-add, one bit per cycle.
REQ-018 MUL shall last exactly W edges (counter 0..W-1) and then enter ADD.
REQ-019 ADD: one edge shall add zero-extended mod to the 2W-bit product; rem_ok and div_zero shall be computed from the latched operands; the FSM then enters DONE.
REQ-020 Latency: out_valid shall rise W+1 edges after the accepting edge (33 edges for W=32).
REQ-021 DONE: out_valid=1, and dividend, rem_ok and div_zero shall be stable; on the edge with out_ready=1 the FSM shall return to IDLE.
REQ-022 in_ready shall be 0 in MUL, ADD and DONE; in_valid is ignored there and no request shall be queued.
REQ-023 Width rule: the maximum result (2^W-1)^2 + (2^W-1) < 2^(2W), so no overflow flag is needed; the intermediate adder shall be W+1 bits to hold its carry.
REQ-024 divisor=0 shall not be an error: the result shall equal mod, with div_zero=1 and rem_ok=0.
REQ-025 quo=0 shall still take the full W cycles; there shall be no early termination.
REQ-026 Result outputs shall hold their last values outside DONE; they are qualified only by out_valid.

Reset
REQ-027 rst_n low shall asynchronously force state=IDLE, counter=0, accumulator=0, latched operands=0, out_valid=0, dividend=0, rem_ok=0 and div_zero=0.
REQ-028 in_ready shall read 1 during reset.
REQ-029 Reset in MUL, ADD or DONE shall abort the operation with no output pulse; the first request after rst_n rises shall be accepted normally.
REQ-030 Reset release shall be synchronised externally; the block shall not add a synchronizer.

Structure
REQ-031 Package div_recon_pkg shall hold W, the 2-bit state enum (IDLE/MUL/ADD/DONE) and the counter width constant.
REQ-032 The W+1-bit accumulate step shall reuse the existing adder_32bits with Ctr=0 as the only sub-module; all other logic shall be inline.

Verification
REQ-033 quo=3, divisor=7, mod=2 -> dividend=0x17 (23), rem_ok=1, div_zero=0, out_valid exactly 33 edges after the accepting edge.
REQ-034 quo=0xFFFFFFFF, divisor=0xFFFFFFFF, mod=0xFFFFFFFE -> dividend=0xFFFFFFFE_FFFFFFFF, rem_ok=1.
REQ-035 quo=9, divisor=0, mod=5 -> dividend=5, div_zero=1, rem_ok=0.
REQ-036 out_ready held low 10 cycles in DONE -> out_valid and dividend stable throughout; a second in_valid pulse during MUL is ignored (in_ready=0), and only one result is produced.
REQ-037 rst_n pulsed low at MUL cycle 15 -> all outputs go to 0 immediately, no out_valid; a following request quo=1, divisor=1, mod=0 yields dividend=1.
REQ-038 Randomised back-to-back requests with out_ready always 1 -> every dividend matches the reference quo*divisor+mod, and throughput is one result per 34 cycles.
